// File: rtl/i2s_clk_gen_if.sv
// i2s_clk_gen_if
// Groups the control inputs and the generated clock/strobe outputs of
// i2s_clk_gen so the serializer/deserializer side can take them as one bundle.
//   en, div_half                      : run request and BCLK half-period divider
//   bclk, lrclk                       : generated bit clock and word select
//   bclk_rise_stb, bclk_fall_stb      : one-clk strobes aligned with bclk edges
//   bit_idx, frame_start, active      : slot bit position, frame marker, run flag
// master = the generator, slave = its consumer/controller.
interface i2s_clk_gen_if #(
    parameter int DIV_W = 8,
    parameter int BIT_W = 5
);
    logic             en;
    logic [DIV_W-1:0] div_half;
    logic             bclk;
    logic             lrclk;
    logic             bclk_rise_stb;
    logic             bclk_fall_stb;
    logic [BIT_W-1:0] bit_idx;
    logic             frame_start;
    logic             active;

    modport master (
        input  en, div_half,
        output bclk, lrclk, bclk_rise_stb, bclk_fall_stb, bit_idx, frame_start, active
    );

    modport slave (
        output en, div_half,
        input  bclk, lrclk, bclk_rise_stb, bclk_fall_stb, bit_idx, frame_start, active
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen
// Generates I2S BCLK/LRCLK from the system clock with a runtime divider,
// a configurable slot width and a start / graceful-stop enable that only
// acts on frame boundaries, so a frame is never truncated.
// Ports:
//   clk    : system clock, all logic on the rising edge
//   rst_n  : synchronous reset, active-low
//   bus    : i2s_clk_gen_if.master (en, div_half in; clocks, strobes,
//            bit_idx, frame_start, active out). Every output is a flop.
module i2s_clk_gen #(
    parameter int DIV_W     = 8,
    parameter int SLOT_BITS = 32,
    parameter int BIT_W     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    i2s_clk_gen_if.master bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             frame_start_q, frame_start_d;
    logic             active_q, active_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        bit_idx_d     = bit_idx_q;
        active_d      = active_q;
        rise_d        = 1'b0;
        fall_d        = 1'b0;
        frame_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                div_d     = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                bit_idx_d = '0;
                active_d  = 1'b0;
                if (bus.en) begin
                    state_d       = RUN;
                    div_d         = bus.div_half;
                    active_d      = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != div_q) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!bclk_q) begin
                        bclk_d = 1'b1;
                        rise_d = 1'b1;
                    end else if (bit_idx_q != LAST_BIT) begin
                        bclk_d    = 1'b0;
                        fall_d    = 1'b1;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end else if (!lrclk_q) begin
                        // Mid-frame left->right switch: en is not consulted here.
                        bclk_d    = 1'b0;
                        fall_d    = 1'b1;
                        bit_idx_d = '0;
                        lrclk_d   = 1'b1;
                    end else if (bus.en) begin
                        // Frame boundary while still enabled: next frame starts
                        // and picks up the new divider.
                        bclk_d        = 1'b0;
                        fall_d        = 1'b1;
                        bit_idx_d     = '0;
                        lrclk_d       = 1'b0;
                        frame_start_d = 1'b1;
                        div_d         = bus.div_half;
                    end else begin
                        // Graceful stop: land directly on idle values, no
                        // strobe and no frame_start on this final edge.
                        state_d   = IDLE;
                        bclk_d    = 1'b0;
                        lrclk_d   = 1'b0;
                        bit_idx_d = '0;
                        div_d     = '0;
                        active_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            div_q         <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            bit_idx_q     <= '0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            bit_idx_q     <= bit_idx_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
        end
    end

    assign bus.bclk          = bclk_q;
    assign bus.lrclk         = lrclk_q;
    assign bus.bclk_rise_stb = rise_q;
    assign bus.bclk_fall_stb = fall_q;
    assign bus.bit_idx       = bit_idx_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.active        = active_q;
endmodule
